intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//   Parametrised interrupt controller for the basic CPU. Captures rising edges on N_INTR
//   interrupt lines into pending latches, applies a mask and fixed priority, and raises a
//   request with a vector address to the CPU control unit over a req/ack handshake.
//   Tracks the in-service interrupt until the CPU signals return-from-interrupt.
//   Sits between the peripheral interrupt lines and the CPU PC-load mux.
// PARAMETERS
//   N_INTR      8            number of interrupt lines (1..32)
//   ID_W        3            width of channel index; must satisfy 2**ID_W >= N_INTR
//   ADDR_WIDTH  10           width of the vector address (matches the CPU PC)
//   VEC_BASE    10'd860      vector of channel 0 (10'b1101011100)
//   VEC_STRIDE  20           address spacing between consecutive channel vectors
// PORTS
//   clk         in   1           system clock, rising edge
//   reset       in   1           asynchronous, active-high reset
//   intr_in     in   N_INTR      raw interrupt lines, rising-edge sensitive
//   mask_we     in   1           write enable for the mask register
//   mask_in     in   N_INTR      new mask value (1 = channel masked)
//   intr_ack    in   1           CPU accepts the current request
//   intr_ret    in   1           CPU finished servicing (reti), one-cycle pulse
//   intr_req    out  1           interrupt request to CPU
//   intr_dir    out  ADDR_WIDTH  vector address of requested/in-service channel
//   intr_id     out  ID_W        index of requested/in-service channel
//   intr_busy   out  1           an interrupt is in service
//   intr_pend   out  N_INTR      pending latches (status)
//   intr_mask   out  N_INTR      current mask register
// BEHAVIOUR
//   - Reset (async): intr_req=0, intr_dir=0, intr_id=0, intr_busy=0, intr_pend=0,
//     intr_mask=0 (all enabled), edge-history register=0, state=IDLE.
//   - Edge detect: pend[i] set on the clk edge where intr_in[i]=1 and prev[i]=0; prev<=intr_in.
//     A line already high when reset releases counts as an edge. Levels held high do not re-set.
//   - Mask: mask_we=1 loads mask_in at the clk edge. Masked pending bits are retained, never requested.
//   - Priority: lowest index among (pend & ~mask) wins.
//   - Vector: intr_dir = VEC_BASE + id*VEC_STRIDE, truncated mod 2**ADDR_WIDTH (wraps silently).
//   - FSM IDLE -> REQ -> SERV -> IDLE:
//     IDLE: if any (pend & ~mask) at edge: latch id and vector, intr_req<=1, go REQ.
//     REQ : intr_req, intr_id, intr_dir frozen until ack, even if a higher-priority line
//           arrives or the channel is masked meanwhile. On intr_ack: intr_req<=0,
//           intr_busy<=1, clear pend[id], go SERV.
//     SERV: intr_id/intr_dir hold in-service channel. On intr_ret: intr_busy<=0, go IDLE.
//           No nesting; new edges only accumulate in pend.
//   - Latency: edge sampled at edge E0 -> pend set after E0 -> intr_req high after E1.
//     Ack sampled at edge -> busy high same edge. After ret, next request earliest 1 edge later.
//   - Simultaneous: new edge on channel id in the same cycle its pend is cleared by ack ->
//     set wins, pend[id] stays 1. mask_we coincident with IDLE evaluation: old mask is used.
//   - intr_ack outside REQ and intr_ret outside SERV are ignored.
//   - reset mid-operation aborts any request/service; pending edges are lost.
// CONFIGURATION
//   INTR_SYNC_EN defined: intr_in passes through a 2-flop synchroniser (reset 0) before
//     edge detection; request latency becomes 4 edges from first sampling of the line.
//   Not defined: intr_in used directly; inputs must be synchronous to clk; latency 2 edges.
// TESTING  (defaults: N_INTR=8, VEC_BASE=860, VEC_STRIDE=20, macro off unless stated)
//   1. pulse intr_in[2] one cycle -> intr_req=1 after 2 edges, intr_dir=900, intr_id=2;
//      ack -> intr_req=0, intr_busy=1, intr_pend[2]=0; ret -> intr_busy=0.
//   2. intr_in[7] and intr_in[3] rise same cycle -> first request dir=920 id=3; after
//      ack+ret next request dir=1000 id=7 (distinct vector for channel 7).
//   3. mask_in=8'h20 written, pulse intr_in[5] -> no request, intr_pend=8'h20; write mask 0
//      -> intr_req after 1 edge, dir=960.
//   4. in REQ for ch2 (no ack), pulse ch0 -> dir stays 900; ack, ret -> request dir=860;
//      stray intr_ret in IDLE and intr_ack in SERV cause no state change.
//   5. assert reset mid-SERV between clk edges -> intr_busy, intr_req, intr_pend, intr_mask
//      all 0 immediately without a clk edge.
//   6. INTR_SYNC_EN defined, pulse intr_in[1] held 1 cycle -> intr_req after 4 edges, dir=880.

Source files
------------

// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_if
// Brief    : Interrupt lines, mask write port and CPU req/ack/ret handshake.
// Revision : 1.0
// ============================================================================
interface intr_ctrl_if #(
    parameter int N_INTR     = 8,
    parameter int ID_W       = 3,
    parameter int ADDR_WIDTH = 10
);
    logic [N_INTR-1:0]     intr_in;
    logic                  mask_we;
    logic [N_INTR-1:0]     mask_in;
    logic                  intr_ack;
    logic                  intr_ret;
    logic                  intr_req;
    logic [ADDR_WIDTH-1:0] intr_dir;
    logic [ID_W-1:0]       intr_id;
    logic                  intr_busy;
    logic [N_INTR-1:0]     intr_pend;
    logic [N_INTR-1:0]     intr_mask;

    // Peripheral/CPU side
    modport master (
        output intr_in, mask_we, mask_in, intr_ack, intr_ret,
        input  intr_req, intr_dir, intr_id, intr_busy, intr_pend, intr_mask
    );

    // Controller side
    modport slave (
        input  intr_in, mask_we, mask_in, intr_ack, intr_ret,
        output intr_req, intr_dir, intr_id, intr_busy, intr_pend, intr_mask
    );
endinterface
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Brief    : Edge-captured, maskable, fixed-priority interrupt controller with
//            req/ack/ret handshake. Define INTR_SYNC_EN to add a 2-flop input
//            synchroniser ahead of edge detection.
// Revision : 1.0
// ============================================================================
module intr_ctrl #(
    parameter int                    N_INTR     = 8,
    parameter int                    ID_W       = 3,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = ADDR_WIDTH'(860),
    parameter int                    VEC_STRIDE = 20
) (
    input  wire logic  clk,
    input  wire logic  reset,
    intr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_req;
    logic                  r_busy;
    logic [ID_W-1:0]       r_id;
    logic [ADDR_WIDTH-1:0] r_dir;
    logic [N_INTR-1:0]     r_pend;
    logic [N_INTR-1:0]     r_mask;
    logic [N_INTR-1:0]     r_prev;

    logic [N_INTR-1:0]     w_line;
    logic [N_INTR-1:0]     w_rise;
    logic [N_INTR-1:0]     w_elig;
    logic [N_INTR-1:0]     w_clr;
    logic                  w_any;
    logic [ID_W-1:0]       w_win_id;
    logic [ADDR_WIDTH-1:0] w_vec;
    logic                  w_ack_take;

`ifdef INTR_SYNC_EN
    logic [N_INTR-1:0] r_sync1;
    logic [N_INTR-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.intr_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;
`else
    assign w_line = bus.intr_in;
`endif

    // History resets to 0 so a line already high at reset release reads as an edge.
    assign w_rise     = w_line & ~r_prev;
    assign w_elig     = r_pend & ~r_mask;
    assign w_ack_take = (r_state == S_REQ) && bus.intr_ack;
    assign w_clr      = w_ack_take ? (N_INTR'(1) << r_id) : '0;

    // Scanning downwards leaves the lowest eligible index as the winner.
    always_comb begin
        w_any    = 1'b0;
        w_win_id = '0;
        for (int i = N_INTR - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any    = 1'b1;
                w_win_id = ID_W'(i);
            end
        end
    end

    // Arithmetic kept at ADDR_WIDTH so the vector wraps modulo 2**ADDR_WIDTH.
    assign w_vec = VEC_BASE + ADDR_WIDTH'(w_win_id) * ADDR_WIDTH'(VEC_STRIDE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_prev <= w_line;
            // A fresh edge on the channel being acknowledged must survive the clear.
            r_pend <= (r_pend & ~w_clr) | w_rise;
            if (bus.mask_we) begin
                r_mask <= bus.mask_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_id    <= '0;
            r_dir   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win_id;
                        r_dir   <= w_vec;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.intr_ack) begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SERV;
                    end
                end
                S_SERV: begin
                    if (bus.intr_ret) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.intr_req  = r_req;
    assign bus.intr_dir  = r_dir;
    assign bus.intr_id   = r_id;
    assign bus.intr_busy = r_busy;
    assign bus.intr_pend = r_pend;
    assign bus.intr_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl
// Brief    : Directed plus randomized bench for intr_ctrl with a queue-based
//            scoreboard fed by a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_intr_ctrl;
    localparam int N      = 8;
    localparam int IDW    = 3;
    localparam int AW     = 10;
    localparam int BASE   = 860;
    localparam int STRIDE = 20;
`ifdef INTR_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    intr_ctrl_if #(.N_INTR(N), .ID_W(IDW), .ADDR_WIDTH(AW)) bus ();

    intr_ctrl #(
        .N_INTR(N), .ID_W(IDW), .ADDR_WIDTH(AW),
        .VEC_BASE(10'd860), .VEC_STRIDE(STRIDE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int id;
        int dir;
    } exp_t;
    exp_t exp_q[$];

    logic [N-1:0] m_pend, m_mask, m_prev, m_s1, m_s2;
    logic [N-1:0] m_line, m_rise, m_clr;
    bit           m_req, m_busy;
    int           m_id, m_dir;

    function automatic int vec_of(input int id);
        return (BASE + id * STRIDE) % (1 << AW);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_req = 0; m_busy = 0; m_id = 0; m_dir = 0;
            exp_q.delete();
        end else begin
`ifdef INTR_SYNC_EN
            m_line = m_s2;
            m_s2   = m_s1;
            m_s1   = bus.intr_in;
`else
            m_line = bus.intr_in;
`endif
            m_rise = m_line & ~m_prev;
            m_clr  = '0;
            if (m_busy) begin
                if (bus.intr_ret) m_busy = 0;
            end else if (m_req) begin
                if (bus.intr_ack) begin
                    m_req = 0;
                    m_busy = 1;
                    m_clr[m_id] = 1'b1;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && !m_mask[i]) begin
                        m_id  = i;
                        m_dir = vec_of(i);
                        m_req = 1;
                        exp_q.push_back('{i, vec_of(i)});
                        break;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_rise;
            if (bus.mask_we) m_mask = bus.mask_in;
            m_prev = m_line;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit   prev_req = 0;
    exp_t got;
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 0;
        end else begin
            chk("req", bus.intr_req, 32'(m_req));
            chk("busy", bus.intr_busy, 32'(m_busy));
            chk("pend", bus.intr_pend, 32'(m_pend));
            chk("mask", bus.intr_mask, 32'(m_mask));
            if (bus.intr_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got id %0d dir %0d, none expected", bus.intr_id, bus.intr_dir);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_id", bus.intr_id, got.id);
                    chk("sb_dir", bus.intr_dir, got.dir);
                end
            end
            if (m_req || m_busy) begin
                chk("hold_id", bus.intr_id, m_id);
                chk("hold_dir", bus.intr_dir, m_dir);
            end
            prev_req = bus.intr_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.intr_in  = '0;
        bus.mask_we  = 1'b0;
        bus.mask_in  = '0;
        bus.intr_ack = 1'b0;
        bus.intr_ret = 1'b0;
    endtask

    task automatic pulse(input int ch);
        bus.intr_in[ch] = 1'b1;
        cyc();
        bus.intr_in[ch] = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.intr_req && n < 40) begin
            cyc();
            n++;
        end
        if (!bus.intr_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_req: got no request within %0d cycles, expected one", n);
        end
    endtask

    task automatic do_ack();
        bus.intr_ack = 1'b1;
        cyc();
        bus.intr_ack = 1'b0;
    endtask

    task automatic do_ret();
        bus.intr_ret = 1'b1;
        cyc();
        bus.intr_ret = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        bus.mask_in = m;
        bus.mask_we = 1'b1;
        cyc();
        bus.mask_we = 1'b0;
    endtask

    int n;

    initial begin
        idle_inputs();
        cyc(2);
        chk("rst_req", bus.intr_req, 0);
        chk("rst_dir", bus.intr_dir, 0);
        chk("rst_id", bus.intr_id, 0);
        chk("rst_busy", bus.intr_busy, 0);
        chk("rst_pend", bus.intr_pend, 0);
        chk("rst_mask", bus.intr_mask, 0);
        #2 reset = 1'b0;
        cyc();

        // Single pulse on channel 2, latency counted from the sampling edge
        bus.intr_in[2] = 1'b1;
        cyc();
        bus.intr_in[2] = 1'b0;
        wait_req(n);
        chk("t1_latency", n + 1, LAT);
        chk("t1_dir", bus.intr_dir, 900);
        chk("t1_id", bus.intr_id, 2);
        do_ack();
        chk("t1_ack_req", bus.intr_req, 0);
        chk("t1_ack_busy", bus.intr_busy, 1);
        chk("t1_ack_pend2", bus.intr_pend[2], 0);
        do_ret();
        chk("t1_ret_busy", bus.intr_busy, 0);
        cyc();

        // Two simultaneous edges: lowest index first
        bus.intr_in = 8'h88;
        cyc();
        bus.intr_in = '0;
        wait_req(n);
        chk("t2_dir_a", bus.intr_dir, 920);
        chk("t2_id_a", bus.intr_id, 3);
        do_ack();
        do_ret();
        wait_req(n);
        chk("t2_dir_b", bus.intr_dir, 1000);
        chk("t2_id_b", bus.intr_id, 7);
        do_ack();
        do_ret();
        cyc();

        // Masked channel stays pending, released by unmasking
        write_mask(8'h20);
        pulse(5);
        cyc(LAT + 2);
        chk("t3_masked_req", bus.intr_req, 0);
        chk("t3_masked_pend", bus.intr_pend, 8'h20);
        write_mask(8'h00);
        wait_req(n);
        chk("t3_unmask_latency", n, 1);
        chk("t3_dir", bus.intr_dir, 960);
        do_ack();
        do_ret();
        cyc();

        // Request frozen while a higher-priority line arrives; stray handshakes
        pulse(2);
        wait_req(n);
        chk("t4_dir_first", bus.intr_dir, 900);
        pulse(0);
        cyc(LAT + 2);
        chk("t4_frozen_req", bus.intr_req, 1);
        chk("t4_frozen_dir", bus.intr_dir, 900);
        chk("t4_frozen_id", bus.intr_id, 2);
        do_ack();
        do_ret();
        wait_req(n);
        chk("t4_dir_second", bus.intr_dir, 860);
        do_ack();
        bus.intr_ack = 1'b1;
        cyc();
        bus.intr_ack = 1'b0;
        chk("t4_stray_ack_busy", bus.intr_busy, 1);
        chk("t4_stray_ack_req", bus.intr_req, 0);
        do_ret();
        bus.intr_ret = 1'b1;
        cyc();
        bus.intr_ret = 1'b0;
        chk("t4_stray_ret_busy", bus.intr_busy, 0);
        chk("t4_stray_ret_req", bus.intr_req, 0);

        // New edge on the channel being acknowledged keeps it pending
        pulse(4);
        wait_req(n);
        bus.intr_in[4] = 1'b1;
        bus.intr_ack   = 1'b1;
        cyc();
        bus.intr_in[4] = 1'b0;
        bus.intr_ack   = 1'b0;
        cyc(LAT - 2);
        chk("t4_setwins_pend4", bus.intr_pend[4], 1);
        chk("t4_setwins_busy", bus.intr_busy, 1);
        do_ret();
        wait_req(n);
        chk("t4_setwins_id", bus.intr_id, 4);
        do_ack();
        do_ret();
        cyc();

        // Channel 1 vector, then asynchronous reset in the middle of service
        write_mask(8'h40);
        bus.intr_in[1] = 1'b1;
        cyc();
        bus.intr_in[1] = 1'b0;
        wait_req(n);
        chk("t6_latency", n + 1, LAT);
        chk("t6_dir", bus.intr_dir, 880);
        do_ack();
        pulse(6);
        cyc(LAT);
        chk("t5_pre_busy", bus.intr_busy, 1);
        chk("t5_pre_pend", bus.intr_pend, 8'h40);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_busy", bus.intr_busy, 0);
        chk("t5_async_req", bus.intr_req, 0);
        chk("t5_async_pend", bus.intr_pend, 0);
        chk("t5_async_mask", bus.intr_mask, 0);
        cyc(2);
        #2 reset = 1'b0;
        idle_inputs();
        cyc();

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 11) == 0) bus.intr_in[b] = ~bus.intr_in[b];
            end
            bus.mask_we  = ($urandom_range(0, 31) == 0);
            bus.mask_in  = N'($urandom);
            bus.intr_ack = bus.intr_req  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            bus.intr_ret = bus.intr_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b1;
                cyc();
                #2 reset = 1'b0;
            end
            cyc();
        end

        // Drain outstanding work
        idle_inputs();
        for (int k = 0; k < 40; k++) begin
            bus.intr_ack = bus.intr_req;
            bus.intr_ret = bus.intr_busy;
            cyc();
        end
        idle_inputs();
        cyc(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
